// File: rtl/nr_pkg.sv
// Shared defaults and helpers for the 3x3 noise-reduction window builder.
package nr_pkg;

    localparam int unsigned NR_DATA_W = 8;
    localparam int unsigned NR_IMG_W  = 130;
    localparam int unsigned NR_IMG_H  = 130;
    localparam int unsigned FRAME_PIX = NR_IMG_W * NR_IMG_H;

    // Flat slot of window element (row i, column j), both counted from the top-left corner.
    function automatic int unsigned win_idx(input int unsigned i, input int unsigned j);
        return 3 * i + j;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Fixed-delay line buffer: a circular RAM read before write at one pointer, so data_o is
// the sample pushed exactly DEPTH pushes ago.
module line_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 130
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    assign data_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (push_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are never reset; window validity is gated by the position counters.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/nr_window_3x3.sv
// Builds a registered 3x3 neighbourhood around each interior pixel of a raster stream,
// with centre position and an end-of-frame pulse.
module nr_window_3x3
    import nr_pkg::*;
#(
    parameter int unsigned DATA_W = NR_DATA_W,
    parameter int unsigned IMG_W  = NR_IMG_W,
    parameter int unsigned IMG_H  = NR_IMG_H
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pix,
    output logic                       out_valid,
    output logic [9*DATA_W-1:0]        out_win,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       frame_done
);

    localparam int unsigned      ROW_W    = $clog2(IMG_H);
    localparam int unsigned      COL_W    = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    logic             accept;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign accept = in_valid & ~clr;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // Two chained line delays give the pixels one and two lines above the incoming one.
    logic [DATA_W-1:0] tap_a, tap_b;

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_fifo_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (accept),
        .data_i (in_pix),
        .data_o (tap_a)
    );

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_fifo_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (accept),
        .data_i (tap_a),
        .data_o (tap_b)
    );

    // Column 2 of the window is the live column from the FIFO taps; columns 0..1 are history.
    logic [DATA_W-1:0] col_pix [3];
    logic [DATA_W-1:0] hist_q  [3][2];
    logic [DATA_W-1:0] hist_d  [3][2];
    logic [DATA_W-1:0] win     [3][3];
    logic [9*DATA_W-1:0] win_flat;

    assign col_pix[0] = tap_b;
    assign col_pix[1] = tap_a;
    assign col_pix[2] = in_pix;

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < 3; i++) begin
            win[i][0]    = hist_q[i][0];
            win[i][1]    = hist_q[i][1];
            win[i][2]    = col_pix[i];
            hist_d[i][0] = accept ? hist_q[i][1] : hist_q[i][0];
            hist_d[i][1] = accept ? col_pix[i]   : hist_q[i][1];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_flat[DATA_W*win_idx(i, j) +: DATA_W] = win[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    hist_q[i][j] <= '0;
                end
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    // The c >= 2 gate also keeps columns carried over from the previous line out of a window.
    logic emit, last_pix;

    assign emit     = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign last_pix = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);

    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [9*DATA_W-1:0] out_win_q, out_win_d;
    logic [ROW_W-1:0]    out_row_q, out_row_d;
    logic [COL_W-1:0]    out_col_q, out_col_d;

    always_comb begin
        out_valid_d  = emit;
        frame_done_d = last_pix;
        out_win_d    = out_win_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        if (emit) begin
            out_win_d = win_flat;
            out_row_d = row_q - 1'b1;
            out_col_d = col_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_win_q    <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_win_q    <= out_win_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_win    = out_win_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

endmodule

// File: tb/tb_nr_window_3x3.sv
// Bench for nr_window_3x3: a 5x4 instance for window/clr/reset behaviour and a default
// 130x130 instance for full-frame counts, both checked against a frame-image model.
module tb_nr_window_3x3;

    localparam int SW = 5;
    localparam int SH = 4;
    localparam int BW = 130;
    localparam int BH = 130;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        clr_s = 1'b0, vld_s = 1'b0;
    logic [7:0]  pix_s = '0;
    logic        ov_s, fd_s;
    logic [71:0] win_s;
    logic [1:0]  row_s;
    logic [2:0]  col_s;

    logic        clr_b = 1'b0, vld_b = 1'b0;
    logic [7:0]  pix_b = '0;
    logic        ov_b, fd_b;
    logic [71:0] win_b;
    logic [7:0]  row_b;
    logic [7:0]  col_b;

    nr_window_3x3 #(
        .DATA_W (8),
        .IMG_W  (SW),
        .IMG_H  (SH)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_s),
        .in_valid   (vld_s),
        .in_pix     (pix_s),
        .out_valid  (ov_s),
        .out_win    (win_s),
        .out_row    (row_s),
        .out_col    (col_s),
        .frame_done (fd_s)
    );

    nr_window_3x3 #(
        .DATA_W (8),
        .IMG_W  (BW),
        .IMG_H  (BH)
    ) u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_b),
        .in_valid   (vld_b),
        .in_pix     (pix_b),
        .out_valid  (ov_b),
        .out_win    (win_b),
        .out_row    (row_b),
        .out_col    (col_b),
        .frame_done (fd_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Model: the current frame as a 2-D image plus the raster position of the next pixel.
    logic [7:0]  img [BH][BW];
    bit          big_sel;
    int          W, H;
    int          m_row, m_col;
    logic [71:0] e_win;
    int          e_row, e_col;
    int          acc_cnt, dut_wins, first_acc;
    int          fd_acc[$];

    task automatic model_reset();
        m_row     = 0;
        m_col     = 0;
        e_win     = '0;
        e_row     = 0;
        e_col     = 0;
        acc_cnt   = 0;
        dut_wins  = 0;
        first_acc = -1;
        fd_acc.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] p, input logic c);
        logic        ev, ef, ov, fd;
        logic [71:0] ow;
        int          orow, ocol;
        if (big_sel) begin
            vld_b = v; pix_b = p; clr_b = c;
        end else begin
            vld_s = v; pix_s = p; clr_s = c;
        end
        @(posedge clk);
        ev = 1'b0;
        ef = 1'b0;
        if (c) begin
            m_row = 0;
            m_col = 0;
        end else if (v) begin
            acc_cnt++;
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                ev    = 1'b1;
                e_row = m_row - 1;
                e_col = m_col - 1;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        e_win[8*(3*i+j) +: 8] = img[m_row-2+i][m_col-2+j];
                    end
                end
            end
            ef = (m_row == H - 1) && (m_col == W - 1);
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row++;
                if (m_row == H) m_row = 0;
            end
        end
        #1;
        if (big_sel) begin
            ov = ov_b; fd = fd_b; ow = win_b; orow = int'(row_b); ocol = int'(col_b);
        end else begin
            ov = ov_s; fd = fd_s; ow = win_s; orow = int'(row_s); ocol = int'(col_s);
        end
        if (ov) begin
            dut_wins++;
            if (first_acc < 0) first_acc = acc_cnt;
        end
        if (fd) begin
            fd_acc.push_back(acc_cnt);
            check_eq("fd_centre", 72'(orow * 256 + ocol), 72'((H - 2) * 256 + (W - 2)));
        end
        check_eq("out_valid", 72'(ov), 72'(ev));
        check_eq("frame_done", 72'(fd), 72'(ef));
        check_eq("out_win", ow, e_win);
        check_eq("out_row", 72'(orow), 72'(e_row));
        check_eq("out_col", 72'(ocol), 72'(e_col));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld_s = 1'b0; clr_s = 1'b0; pix_s = '0;
        vld_b = 1'b0; clr_b = 1'b0; pix_b = '0;
        #1;
        check_eq("rst_small_ctl", 72'({ov_s, fd_s, row_s, col_s}), 72'(0));
        check_eq("rst_small_win", win_s, 72'(0));
        check_eq("rst_big_ctl", 72'({ov_b, fd_b, row_b, col_b}), 72'(0));
        check_eq("rst_big_win", win_b, 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic small_frame_ramp();
        dut_wins  = 0;
        first_acc = -1;
        acc_cnt   = 0;
        for (int k = 0; k < SW * SH; k++) step(1'b1, 8'(k), 1'b0);
        check_eq("first_win_accept", 72'(first_acc), 72'(13));
        check_eq("wins_per_frame", 72'(dut_wins), 72'(6));
    endtask

    initial begin
        int base;
        big_sel = 1'b0;
        W = SW;
        H = SH;
        do_reset();

        // Continuous ramp frame, then a couple of idle cycles.
        small_frame_ramp();
        step(1'b0, 8'hAA, 1'b0);
        step(1'b0, 8'h55, 1'b0);

        // Same frame with in_valid toggling every cycle.
        dut_wins = 0;
        for (int k = 0; k < SW * SH; k++) begin
            step(1'b1, 8'(k), 1'b0);
            step(1'b0, 8'hFF, 1'b0);
        end
        check_eq("wins_toggle", 72'(dut_wins), 72'(6));

        // clr at pixel 7 with in_valid held high; new data follows.
        for (int k = 0; k < 7; k++) step(1'b1, 8'(k), 1'b0);
        step(1'b1, 8'd7, 1'b1);
        base      = acc_cnt;
        first_acc = -1;
        dut_wins  = 0;
        for (int k = 0; k < SW * SH; k++) step(1'b1, 8'(100 + k), 1'b0);
        check_eq("clr_first_win", 72'(first_acc - base), 72'(13));
        check_eq("clr_wins", 72'(dut_wins), 72'(6));

        // Asynchronous reset mid-frame, then the ramp frame again.
        for (int k = 0; k < 9; k++) step(1'b1, 8'($urandom), 1'b0);
        do_reset();
        small_frame_ramp();

        // Random data, random gaps, occasional clr.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 60) == 0));
        end

        // Default geometry: two back-to-back frames.
        big_sel = 1'b1;
        W = BW;
        H = BH;
        do_reset();
        for (int k = 0; k < BW * BH; k++) step(1'b1, 8'(k), 1'b0);
        check_eq("big_wins_f0", 72'(dut_wins), 72'(16384));
        dut_wins = 0;
        for (int k = BW * BH; k < 2 * BW * BH; k++) step(1'b1, 8'(k), 1'b0);
        check_eq("big_wins_f1", 72'(dut_wins), 72'(16384));
        check_eq("fd_count", 72'(fd_acc.size()), 72'(2));
        if (fd_acc.size() == 2) begin
            check_eq("fd_at_0", 72'(fd_acc[0]), 72'(16900));
            check_eq("fd_at_1", 72'(fd_acc[1]), 72'(33800));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
